fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the pipelined MIPS core. Holds the fetch PC (PCF), issues requests to instruction memory over a req/ack handshake, and drives the IF/ID pipeline register (InstrD, PCPlus4D, validD). It sits directly upstream of decode and the hazard unit:
- it consumes the hazard unit's `stallF`/`stallD` and decode's branch redirect;
- it reports memory wait cycles so they can be folded into the stall logic.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PCF value after reset

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- stallF  in  1  hold PCF and the fetched instruction (from hazard unit)
- stallD  in  1  hold the IF/ID register (from hazard unit)
- PCSrcD  in  1  taken branch resolved in decode; honoured only when stallD=0
- PCBranchD  in  32  branch target; valid when PCSrcD=1
- imem_req  out  1  instruction read request
- imem_addr  out  32  word address of the request; stable while imem_req=1 and no ack
- imem_ack  in  1  read complete this cycle; legal only while imem_req=1
- imem_rdata  in  32  instruction; valid with imem_ack
- ImemWaitF  out  1  fetch has no instruction this cycle because memory is pending
- InstrD  out  32  IF/ID instruction
- PCPlus4D  out  32  IF/ID PC+4
- validD  out  1  IF/ID holds a real instruction (0 = bubble)

## Operation
- Redirect is `PCSrcD & ~stallD`. `PCPlus4F = PCF + 4`, taken modulo 2^32 (wrap, no carry out).
- Request address register `reqA` is loaded with PCF when a request starts. `imem_addr = reqA`. `imem_req` is forced to 0 while reset=0.
- Handshake: once raised, req and addr hold until an ack. Ack in the same cycle as req raises is legal (zero-wait). The memory abandons any outstanding request when reset is asserted.
- One-entry holding buffer (`bufI`) keeps a fetched instruction across a stall.

State machine (reset state FETCH):
- **FETCH**: `imem_req=1`, `reqA=PCF`.
  - ack & redirect: discard rdata, `PCF<=PCBranchD`, stay FETCH.
  - ack & ~stallF: `PCF<=PCPlus4F`, instruction available for IF/ID.
  - ack & stallF: `bufI<=rdata`, go HOLD.
  - no ack & redirect: `PCF<=PCBranchD`, go DROP, keeping the old reqA.
  - no ack otherwise: stay FETCH.
- **HOLD**: `imem_req=0`, available instruction = bufI.
  - redirect: `PCF<=PCBranchD`, go FETCH, bufI discarded.
  - ~stallF: `PCF<=PCPlus4F`, go FETCH.
  - otherwise stay HOLD.
- **DROP**: `imem_req=1` with the stale reqA.
  - ack: discard rdata, go FETCH; PCF already holds the target.
  - redirect: `PCF<=PCBranchD`, stay DROP.
- **ImemWaitF** = `(FETCH & ~imem_ack) | DROP`.
- **IF/ID update**, evaluated in this order:
  - ~stallD & redirect: `InstrD<=0`, `PCPlus4D<=0`, `validD<=0` (flush).
  - ~stallD & instruction available & ~stallF: `InstrD<=instr`, `PCPlus4D<=PCPlus4F`, `validD<=1`.
  - ~stallD otherwise: bubble (`InstrD<=0`, `PCPlus4D<=0`, `validD<=0`).
  - stallD: hold.
- **stallF=1 with stallD=0**: PC/buffer hold and IF/ID takes a bubble. No instruction is lost or duplicated.

## Timing
- Reset (reset=0 at an edge):
  - PCF=RESET_PC, state=FETCH, bufI=0.
  - InstrD=0, PCPlus4D=0, validD=0.
  - imem_req=0 while reset is low.
- Reset asserted mid-request or mid-DROP: the outstanding transfer is abandoned. After release, the first request goes to RESET_PC.
- First request is issued in the first cycle with reset=1.
- Zero-wait memory: one instruction per cycle. An instruction fetched in cycle N appears on InstrD/validD after edge N.
- Each memory wait cycle inserts one bubble (validD=0) unless stallD is high.
- Redirect in cycle N: PCF=PCBranchD after edge N. IF/ID is flushed at edge N.
  - Without an outstanding request, the target is requested in cycle N+1.
  - With an outstanding request, the target request starts the cycle after the stale ack.
- Redirect with stallD=1 is ignored entirely.

## Test plan
- **Straight-line, zero-wait**: reset release, then ack every cycle with rdata=0x20000000+PC → imem_addr 0x0,0x4,0x8…; InstrD tracks one cycle behind; validD=1 continuously; PCPlus4D=0x4,0x8,…
- **Stall in FETCH/HOLD**: ack at PC=0x8 with stallF=stallD=1 for 3 cycles → imem_req=0 during HOLD; InstrD/validD held; PCF=0x8. On release, InstrD=rdata(0x8) and the next request is to 0xC.
- **Redirect, no outstanding request**: PCSrcD=1, PCBranchD=0x100 while ack arrives for 0x10 → rdata(0x10) discarded; validD=0 next cycle; next imem_addr=0x100.
- **Redirect during wait**: request to 0x20 pending, PCSrcD=1, target 0x200 → imem_addr stays 0x20 until ack (DROP); ImemWaitF=1 throughout; that data is never in InstrD; next request is 0x200.
- **Boundaries**: RESET_PC=0xFFFFFFFC → second request to 0x00000000, PCPlus4D=0x0. PCSrcD=1 with stallD=1 → PCF unchanged.
- **Reset mid-operation**: assert reset during DROP → imem_req=0, validD=0, and InstrD=0 after the edge. After release, first imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : MIPS instruction-fetch stage. Owns the fetch PC, runs the
//               req/ack handshake to instruction memory, keeps a one-entry
//               buffer across stalls and drives the IF/ID pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallF,
    input  logic        stallD,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ImemWaitF,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        validD
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pcf;
    logic [31:0] r_req_addr;
    logic [31:0] r_buf;

    logic        w_redirect;
    logic [31:0] w_pcplus4f;
    logic        w_avail;
    logic [31:0] w_instr;

    // A decode redirect only counts when decode itself is not stalled.
    assign w_redirect = PCSrcD & ~stallD;
    assign w_pcplus4f = r_pcf + 32'd4;

    // In FETCH the request address is the live PC (it cannot move without an
    // ack); in DROP the stale captured address must be held until its ack.
    assign imem_addr = (r_state == DROP) ? r_req_addr : r_pcf;
    assign imem_req  = reset & (r_state != HOLD);
    assign ImemWaitF = ((r_state == FETCH) & ~imem_ack) | (r_state == DROP);

    // Select the instruction offered to IF/ID this cycle, if any.
    always_comb begin
        w_avail = 1'b0;
        w_instr = 32'h0;
        case (r_state)
            FETCH: begin
                w_avail = imem_ack;
                w_instr = imem_rdata;
            end
            HOLD: begin
                w_avail = 1'b1;
                w_instr = r_buf;
            end
            default: begin
                w_avail = 1'b0;
                w_instr = 32'h0;
            end
        endcase
    end

    // Fetch state machine: PC, captured request address and holding buffer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= FETCH;
            r_pcf      <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_buf      <= 32'h0;
        end else begin
            case (r_state)
                FETCH: begin
                    r_req_addr <= r_pcf;
                    if (imem_ack) begin
                        if (w_redirect) begin
                            r_pcf <= PCBranchD;
                        end else if (!stallF) begin
                            r_pcf <= w_pcplus4f;
                        end else begin
                            r_buf   <= imem_rdata;
                            r_state <= HOLD;
                        end
                    end else if (w_redirect) begin
                        r_pcf   <= PCBranchD;
                        r_state <= DROP;
                    end
                end
                HOLD: begin
                    if (w_redirect) begin
                        r_pcf   <= PCBranchD;
                        r_state <= FETCH;
                    end else if (!stallF) begin
                        r_pcf   <= w_pcplus4f;
                        r_state <= FETCH;
                    end
                end
                DROP: begin
                    // A newer redirect retargets the PC even on the stale ack.
                    if (w_redirect) begin
                        r_pcf <= PCBranchD;
                    end
                    if (imem_ack) begin
                        r_state <= FETCH;
                    end
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

    // IF/ID register: flush on redirect, load on a usable instruction,
    // otherwise insert a bubble; frozen entirely while decode stalls.
    always_ff @(posedge clk) begin
        if (!reset) begin
            InstrD   <= 32'h0;
            PCPlus4D <= 32'h0;
            validD   <= 1'b0;
        end else if (!stallD) begin
            if (w_redirect) begin
                InstrD   <= 32'h0;
                PCPlus4D <= 32'h0;
                validD   <= 1'b0;
            end else if (w_avail && !stallF) begin
                InstrD   <= w_instr;
                PCPlus4D <= w_pcplus4f;
                validD   <= 1'b1;
            end else begin
                InstrD   <= 32'h0;
                PCPlus4D <= 32'h0;
                validD   <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
